// File: rtl/gate_sweep_checker.sv
// Sweeps a 2-input gate under test through {A,B} = 00,01,10,11 and compares Y with EXPECTED.
// Latency: 4*(SETTLE+1) busy cycles per sweep, then a one-cycle done pulse. Results are registered.
// Backpressure: none. start is sampled only in IDLE or DONE and is ignored while busy.
//
// Ports:
//   clk, rst_n      - rising-edge clock, synchronous active-low reset
//   start           - run request
//   A, B            - registered stimulus to the gate under test (A = index[1], B = index[0])
//   Y               - gate response, sampled on the last cycle of each vector
//   busy, done      - sweep in progress / one-cycle end-of-sweep pulse
//   pass, observed, err_count - sweep result. These hold until the next accepted start.
//   first_fail      - {valid, index} of the first mismatch (only with SWEEP_FAIL_LATCH_EN)
//
// Optional feature macro: SWEEP_FAIL_LATCH_EN adds the first_fail output.
module gate_sweep_checker #(
    parameter int unsigned SETTLE   = 2,
    parameter logic [3:0]  EXPECTED = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] observed,
    output logic [2:0] err_count
`ifdef SWEEP_FAIL_LATCH_EN
    ,
    output logic [2:0] first_fail
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    // WAIT covers the cycles between DRIVE and SAMPLE.
    // This gives SETTLE+1 cycles per vector in total.
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t     state;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic       mism;
    logic [2:0] err_next;

    assign mism = (Y != EXPECTED[idx]);

    // The count can never exceed the number of vectors.
    assign err_next = (mism && (err_count != 3'd4)) ? err_count + 3'd1 : err_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            cnt       <= 4'd0;
            A         <= 1'b0;
            B         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            observed  <= 4'd0;
            err_count <= 3'd0;
`ifdef SWEEP_FAIL_LATCH_EN
            first_fail <= 3'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= DRIVE;
                        busy      <= 1'b1;
                        idx       <= 2'd0;
                        A         <= 1'b0;
                        B         <= 1'b0;
                        pass      <= 1'b0;
                        observed  <= 4'd0;
                        err_count <= 3'd0;
`ifdef SWEEP_FAIL_LATCH_EN
                        first_fail <= 3'd0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                DRIVE: begin
                    cnt   <= 4'd1;
                    state <= (SETTLE == 1) ? SAMPLE : WAIT;
                end
                WAIT: begin
                    if (cnt == SETTLE_M1) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    observed[idx] <= Y;
                    err_count     <= err_next;
`ifdef SWEEP_FAIL_LATCH_EN
                    if (mism && !first_fail[2]) begin
                        first_fail <= {1'b1, idx};
                    end
`endif
                    if (idx == 2'd3) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 3'd0);
                    end else begin
                        // A and B are updated only here, which keeps them stable for the whole vector.
                        idx    <= idx + 2'd1;
                        {A, B} <= idx + 2'd1;
                        state  <= DRIVE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
